image_stream_reader: RTL and testbench

//  Raster-scans the frame Memory through its read port (XRead/YRead -> ReadValue, 1-clk registered read).

---
 rtl/asip_image_pkg.sv | 27 ++
 rtl/pixel_skid_fifo.sv | 65 ++++++
 rtl/image_stream_reader.sv | 164 ++++++++++++++++
 tb/tb_image_stream_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asip_image_pkg.sv
// Shared types for the frame raster reader.
//   XW / YW        : widths of the column / row address buses
//   COLOR_MAX      : widest colour the pixel record can carry; narrower
//                    colours are zero-extended on entry and sliced on exit
//   pixel_t        : one buffered pixel (colour, coordinates, last flag)
//   reader_state_t : scan FSM states
package asip_image_pkg;

    localparam int XW        = 9;
    localparam int YW        = 8;
    localparam int COLOR_MAX = 16;

    typedef struct packed {
        logic [COLOR_MAX-1:0] color;
        logic [XW-1:0]        x;
        logic [YW-1:0]        y;
        logic                 last;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO that absorbs the memory read latency.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle (caller guarantees count < 2)
//   push_data   : pixel record to store
//   pop         : remove the head entry this cycle (ignored when empty)
//   head        : oldest stored pixel (zero after reset)
//   count       : number of stored pixels, 0..2
module pixel_skid_fifo
    import asip_image_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  pixel_t     push_data,
    input  logic       pop,
    output pixel_t     head,
    output logic [1:0] count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_pop;

    assign do_pop = pop && (count_reg != 2'd0);

    // Entries only change on a push into their own slot, so the head stays
    // stable while the consumer stalls.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        pixel_t data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count = count_reg;

endmodule

// File: rtl/image_stream_reader.sv
// Raster-scans a frame memory (1-clk registered read) and emits every pixel
// once, row-major, on a valid/ready stream.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   Start              : request a full-frame scan (honoured only when idle)
//   Busy               : scan in progress (SCAN or DRAIN)
//   Done               : one-cycle pulse after the last pixel handshake
//   XRead, YRead       : memory read address
//   ReadValue          : memory read data, valid the cycle after the address
//   PixelValid/Ready   : output stream handshake
//   PixelData/X/Y      : pixel colour and its coordinates
//   LastPixel          : high on the (Width-1, Height-1) beat
module image_stream_reader
    import asip_image_pkg::*;
#(
    parameter int Width     = 50,
    parameter int Height    = 50,
    parameter int ColorBits = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    output logic [XW-1:0]        XRead,
    output logic [YW-1:0]        YRead,
    input  logic [ColorBits-1:0] ReadValue,
    output logic                 PixelValid,
    input  logic                 PixelReady,
    output logic [ColorBits-1:0] PixelData,
    output logic [XW-1:0]        PixelX,
    output logic [YW-1:0]        PixelY,
    output logic                 LastPixel
);

    localparam logic [XW-1:0] X_LAST = XW'(Width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Height - 1);

    reader_state_t state_reg, state_next;
    logic [XW-1:0] x_reg, x_next, xhold_reg;
    logic [YW-1:0] y_reg, y_next, yhold_reg;
    logic          in_flight_reg;
    logic [XW-1:0] tag_x_reg;
    logic [YW-1:0] tag_y_reg;
    logic          tag_last_reg;

    logic          issue;
    logic          pop;
    logic          at_last;
    logic [2:0]    credits;
    pixel_t        push_data;
    pixel_t        head;
    logic [1:0]    count;
    logic          unused_color;

    assign pop     = PixelValid && PixelReady;
    assign at_last = (x_reg == X_LAST) && (y_reg == Y_LAST);
    // Slots already claimed: a read in flight plus pixels buffered.
    assign credits = {2'b00, in_flight_reg} + {1'b0, count};

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                // A pop this cycle frees a slot the new read can use when it
                // lands, which is what keeps the stream at one pixel per clock.
                issue = (credits < (pop ? 3'd3 : 3'd2));
                if (issue) begin
                    if (x_reg == X_LAST) begin
                        x_next = '0;
                        if (y_reg == Y_LAST) begin
                            y_next     = '0;
                            state_next = DRAIN;
                        end else begin
                            y_next = y_reg + YW'(1);
                        end
                    end else begin
                        x_next = x_reg + XW'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            xhold_reg     <= '0;
            yhold_reg     <= '0;
            in_flight_reg <= 1'b0;
            tag_x_reg     <= '0;
            tag_y_reg     <= '0;
            tag_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            in_flight_reg <= issue;
            if (issue) begin
                xhold_reg    <= x_reg;
                yhold_reg    <= y_reg;
                tag_x_reg    <= x_reg;
                tag_y_reg    <= y_reg;
                tag_last_reg <= at_last;
            end
        end
    end

    // The address goes straight out in the issue cycle so the memory samples
    // it at the end of that cycle; otherwise the last address is held.
    assign XRead = issue ? x_reg : xhold_reg;
    assign YRead = issue ? y_reg : yhold_reg;

    always_comb begin
        push_data       = '0;
        push_data.color = COLOR_MAX'(ReadValue);
        push_data.x     = tag_x_reg;
        push_data.y     = tag_y_reg;
        push_data.last  = tag_last_reg;
    end

    pixel_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight_reg),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Only the low ColorBits of the stored colour are meaningful.
    assign unused_color = ^head.color;

    assign PixelValid = (count != 2'd0);
    assign PixelData  = head.color[ColorBits-1:0];
    assign PixelX     = head.x;
    assign PixelY     = head.y;
    assign LastPixel  = PixelValid && head.last;
    assign Busy       = (state_reg == SCAN) || (state_reg == DRAIN);
    assign Done       = (state_reg == DONE);

endmodule

// File: tb/tb_image_stream_reader.sv
module tb_image_stream_reader;

    localparam int WS [4] = '{4, 1, 512, 50};
    localparam int HS [4] = '{3, 1, 1, 50};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sel = 2'd0;
    logic       start_req = 1'b0;
    logic       spam_en = 1'b0;
    logic       ready_val = 1'b0;

    logic [3:0]       start_v, rdy_v, busy_v, done_v, pv_v, lp_v;
    logic [3:0][8:0]  xr_a, px_a;
    logic [3:0][7:0]  yr_a, py_a;
    logic [3:0][2:0]  pd_a;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W = WS[gi];
        localparam int H = HS[gi];
        logic [8:0] xr, px;
        logic [7:0] yr, py;
        logic [2:0] rv, pd;
        logic       busy, done, pv, lp;

        image_stream_reader #(.Width(W), .Height(H), .ColorBits(3)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .Start      (start_v[gi]),
            .Busy       (busy),
            .Done       (done),
            .XRead      (xr),
            .YRead      (yr),
            .ReadValue  (rv),
            .PixelValid (pv),
            .PixelReady (rdy_v[gi]),
            .PixelData  (pd),
            .PixelX     (px),
            .PixelY     (py),
            .LastPixel  (lp)
        );

        // Frame memory model: Image[x][y] = (x + 2*y) mod 8, 1-clk registered read
        always @(posedge clk) rv <= 3'((int'(xr) + 2 * int'(yr)) % 8);

        assign start_v[gi] = (sel == 2'(gi)) && (start_req || (spam_en && busy));
        assign rdy_v[gi]   = (sel == 2'(gi)) && ready_val;
        assign busy_v[gi]  = busy;
        assign done_v[gi]  = done;
        assign pv_v[gi]    = pv;
        assign lp_v[gi]    = lp;
        assign xr_a[gi]    = xr;
        assign yr_a[gi]    = yr;
        assign px_a[gi]    = px;
        assign py_a[gi]    = py;
        assign pd_a[gi]    = pd;
    end

    wire       start_s = start_v[sel];
    wire       busy_s  = busy_v[sel];
    wire       done_s  = done_v[sel];
    wire       pv_s    = pv_v[sel];
    wire       lp_s    = lp_v[sel];
    wire [8:0] xr_s    = xr_a[sel];
    wire [7:0] yr_s    = yr_a[sel];
    wire [8:0] px_s    = px_a[sel];
    wire [7:0] py_s    = py_a[sel];
    wire [2:0] pd_s    = pd_a[sel];

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int         mode = 0;          // 0 ready high, 1 backpressure, 2 random
    int         cyc = 0;
    int         beats = 0;
    int         dones = 0;
    int         exp_x = 0, exp_y = 0;
    int         start_cyc = -1, busy_cyc = -1, first_pv_cyc = -1, done_cyc = -1;
    int         stall_left = 0;
    bit         bp_done = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_last_hs = 1'b0;
    logic [20:0] prev_fields = '0;

    always begin
        logic [20:0] act_b, exp_b;
        logic        exp_last;
        int          w, h;
        @(negedge clk);
        case (mode)
            0: ready_val = 1'b1;
            1: begin
                if (!bp_done && beats == 3) begin
                    bp_done    = 1'b1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    ready_val = 1'b0;
                    stall_left--;
                end else if (beats < 3) begin
                    ready_val = 1'b1;
                end else begin
                    ready_val = 1'($urandom_range(0, 1));
                end
            end
            default: ready_val = 1'($urandom_range(0, 1));
        endcase
        #1;
        cyc++;
        if (!rst_n) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            w = WS[sel];
            h = HS[sel];
            if (start_s && !busy_s && !done_s && start_cyc < 0) start_cyc = cyc;
            if (busy_s && busy_cyc < 0) busy_cyc = cyc;
            if (pv_s && first_pv_cyc < 0) first_pv_cyc = cyc;
            check("done_timing", 64'(done_s), 64'(prev_last_hs));
            if (done_s) begin
                dones++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                check("stall_stable", {42'd0, pv_s, lp_s, py_s, px_s, pd_s}, {42'd0, 1'b1, prev_fields});
            end
            prev_last_hs = 1'b0;
            if (pv_s && ready_val) begin
                exp_last = (exp_x == w - 1) && (exp_y == h - 1);
                act_b = {lp_s, py_s, px_s, pd_s};
                exp_b = {exp_last, 8'(exp_y), 9'(exp_x), 3'((exp_x + 2 * exp_y) % 8)};
                check("beat", 64'(act_b), 64'(exp_b));
                beats++;
                prev_last_hs = lp_s;
                exp_x++;
                if (exp_x == w) begin
                    exp_x = 0;
                    exp_y++;
                end
            end
            prev_stall  = pv_s && !ready_val;
            prev_fields = {lp_s, py_s, px_s, pd_s};
        end
    end

    // ---------------- directed frame table ----------------
    typedef struct {
        int inst;
        int rmode;
        bit spam;
        int exp_beats;
        int exp_span;   // first valid -> Done in cycles; 0 = not checked
    } vec_t;

    vec_t tbl [7];

    task automatic clear_score();
        beats = 0; dones = 0; exp_x = 0; exp_y = 0;
        start_cyc = -1; busy_cyc = -1; first_pv_cyc = -1; done_cyc = -1;
        bp_done = 1'b0; stall_left = 0;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int n;
        sel     = 2'(v.inst);
        mode    = v.rmode;
        spam_en = v.spam;
        clear_score();
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        while (dones == 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (dones == 0) check("frame_timeout", 64'(n), 64'(0));
        repeat (20) @(negedge clk);
        spam_en = 1'b0;
        check("beat_count", 64'(beats), 64'(v.exp_beats));
        check("done_count", 64'(dones), 64'(1));
        check("idle_after", {62'd0, busy_s, pv_s}, 64'(0));
        check("busy_latency", 64'(busy_cyc - start_cyc), 64'(1));
        check("first_valid_latency", 64'(first_pv_cyc - start_cyc), 64'(3));
        if (v.exp_span != 0) check("throughput_span", 64'(done_cyc - first_pv_cyc), 64'(v.exp_span));
        $display("frame %0d: %0dx%0d mode=%0d spam=%0d beats=%0d dones=%0d", idx,
                 WS[v.inst], HS[v.inst], v.rmode, v.spam, beats, dones);
    endtask

    initial begin
        logic [40:0] outs;
        int          n;
        int          b_hold;

        tbl[0] = '{inst: 0, rmode: 0, spam: 1'b0, exp_beats: 12,   exp_span: 12};
        tbl[1] = '{inst: 0, rmode: 1, spam: 1'b0, exp_beats: 12,   exp_span: 0};
        tbl[2] = '{inst: 0, rmode: 2, spam: 1'b1, exp_beats: 12,   exp_span: 0};
        tbl[3] = '{inst: 0, rmode: 0, spam: 1'b1, exp_beats: 12,   exp_span: 12};
        tbl[4] = '{inst: 1, rmode: 0, spam: 1'b0, exp_beats: 1,    exp_span: 1};
        tbl[5] = '{inst: 2, rmode: 0, spam: 1'b0, exp_beats: 512,  exp_span: 512};
        tbl[6] = '{inst: 3, rmode: 0, spam: 1'b0, exp_beats: 2500, exp_span: 2500};

        // Reset state
        repeat (3) @(negedge clk);
        outs = {busy_s, done_s, pv_s, lp_s, xr_s, yr_s, pd_s, px_s, py_s};
        check("reset_outputs", 64'(outs), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i], i);
        end

        // Asynchronous reset in the middle of a 4x3 frame
        sel = 2'd0; mode = 0; spam_en = 1'b0;
        clear_score();
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        while (beats < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat6", 64'(beats >= 6), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        outs = {busy_s, done_s, pv_s, lp_s, xr_s, yr_s, pd_s, px_s, py_s};
        check("async_reset_outputs", 64'(outs), 64'(0));
        b_hold = beats;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {61'd0, busy_s, pv_s, done_s}, 64'(0));
        check("no_beats_after_reset", 64'(beats), 64'(b_hold));
        $display("reset mid-frame: beats before reset=%0d", b_hold);
        run_frame(tbl[0], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
